// File: rtl/rob_commit_unit.sv
`default_nettype none
// ============================================================================
// Module      : rob_commit_unit
// Description : Reorder buffer for the renaming register file. Allocates
//               entries in program order, captures results from the common
//               data bus, retires completed entries in order onto the
//               register file write port and serves operand-tag lookups.
//               Optional macro ROB_CDB_BYPASS_EN adds a combinational
//               CDB-to-lookup forwarding path.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_commit_unit #(
    parameter int TAG  = 7,
    parameter int ADDR = 5,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            alloc_valid,
    input  logic [ADDR-1:0] alloc_rd,
    output logic            alloc_ready,
    output logic [TAG-1:0]  tailD,
    input  logic            cdb_valid,
    input  logic [TAG-1:0]  cdb_tag,
    input  logic [XLEN-1:0] cdb_data,
    input  logic [TAG-1:0]  RT1,
    input  logic [TAG-1:0]  RT2,
    output logic [XLEN:0]   RV1,
    output logic [XLEN:0]   RV2,
    output logic            WE_W,
    output logic [ADDR-1:0] WA_W,
    output logic [XLEN-1:0] WD,
    output logic            empty,
    output logic [TAG:0]    count
);

    localparam int            DEPTH      = 1 << TAG;
    localparam logic [TAG:0]  FULL_COUNT = (TAG+1)'(DEPTH);

    // Entry storage: valid/done as flat vectors, rd/data as arrays
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] done_q,  done_d;
    logic [ADDR-1:0]  rd_q   [DEPTH];
    logic [ADDR-1:0]  rd_d   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [XLEN-1:0]  data_d [DEPTH];

    // Pointers and occupancy
    logic [TAG-1:0]   head_q,  head_d;
    logic [TAG-1:0]   tail_q,  tail_d;
    logic [TAG:0]     count_q, count_d;

    // Registered write-back port
    logic             we_w_q, we_w_d;
    logic [ADDR-1:0]  wa_w_q, wa_w_d;
    logic [XLEN-1:0]  wd_q,   wd_d;

    logic             alloc_fire;
    logic             commit_fire;
    logic             wb_hit;

    // Full is judged on the registered count so a same-cycle commit never
    // frees a slot for that cycle's allocation.
    assign alloc_ready = (count_q != FULL_COUNT);
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign wb_hit      = cdb_valid & valid_q[cdb_tag];
    // Commit decision uses stored state only, so a result landing on head
    // retires one cycle after its broadcast.
    assign commit_fire = valid_q[head_q] & done_q[head_q];

    assign tailD = tail_q;
    assign count = count_q;
    assign empty = (count_q == '0);
    assign WE_W  = we_w_q;
    assign WA_W  = wa_w_q;
    assign WD    = wd_q;

    // Lookup returns {ready, data}; ready requires a live, completed entry
    function automatic logic [XLEN:0] lookup(input logic [TAG-1:0] t);
        logic [XLEN:0] r;
        r = {valid_q[t] & done_q[t], data_q[t]};
`ifdef ROB_CDB_BYPASS_EN
        if (cdb_valid && valid_q[t] && (cdb_tag == t)) begin
            r = {1'b1, cdb_data};
        end
`endif
        return r;
    endfunction

    // Operand lookups for the issue stage
    always_comb begin
        RV1 = lookup(RT1);
        RV2 = lookup(RT2);
    end

    // Next-state: flush wins; otherwise writeback, commit, then allocate
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        rd_d    = rd_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        we_w_d  = 1'b0;
        wa_w_d  = wa_w_q;
        wd_d    = wd_q;

        if (flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wb_hit) begin
                done_d[cdb_tag] = 1'b1;
                data_d[cdb_tag] = cdb_data;
            end
            // Commit captures the pre-edge data; a same-cycle repeat
            // writeback to head is lost along with the entry.
            if (commit_fire) begin
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + TAG'(1);
                we_w_d          = (rd_q[head_q] != '0);
                wa_w_d          = rd_q[head_q];
                wd_d            = data_q[head_q];
            end
            // Tail slot is never valid when allocation is allowed, so this
            // cannot collide with the writeback or commit above.
            if (alloc_fire) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                rd_d[tail_q]    = alloc_rd;
                tail_d          = tail_q + TAG'(1);
            end
            count_d = count_q + (TAG+1)'(alloc_fire) - (TAG+1)'(commit_fire);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            done_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we_w_q  <= 1'b0;
            wa_w_q  <= '0;
            wd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we_w_q  <= we_w_d;
            wa_w_q  <= wa_w_d;
            wd_q    <= wd_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rob_commit_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_commit_unit
// Description : Self-checking bench for rob_commit_unit. Directed scenarios
//               followed by random traffic, all checked against a queue-based
//               program-order model of the reorder buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_commit_unit;

    localparam int TAG   = 7;
    localparam int ADDR  = 5;
    localparam int XLEN  = 32;
    localparam int DEPTH = 128;

    logic            clk;
    logic            rstn;
    logic            flush;
    logic            alloc_valid;
    logic [ADDR-1:0] alloc_rd;
    logic            alloc_ready;
    logic [TAG-1:0]  tailD;
    logic            cdb_valid;
    logic [TAG-1:0]  cdb_tag;
    logic [XLEN-1:0] cdb_data;
    logic [TAG-1:0]  RT1;
    logic [TAG-1:0]  RT2;
    logic [XLEN:0]   RV1;
    logic [XLEN:0]   RV2;
    logic            WE_W;
    logic [ADDR-1:0] WA_W;
    logic [XLEN-1:0] WD;
    logic            empty;
    logic [TAG:0]    count;

    rob_commit_unit #(.TAG(TAG), .ADDR(ADDR), .XLEN(XLEN)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .tailD(tailD),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .RT1(RT1), .RT2(RT2), .RV1(RV1), .RV2(RV2),
        .WE_W(WE_W), .WA_W(WA_W), .WD(WD),
        .empty(empty), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program-order model: front of the queue is the oldest instruction
    typedef struct {
        logic [TAG-1:0]  tag;
        logic [ADDR-1:0] rd;
        bit              done;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            mq[$];
    int              m_tail;
    logic            m_we;
    logic [ADDR-1:0] m_wa;
    logic [XLEN-1:0] m_wd;

    int n_pass;
    int n_total;

    task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    endtask

    function automatic int find(input logic [TAG-1:0] t);
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].tag == t) return i;
        end
        return -1;
    endfunction

    task automatic chk_rv(input string nm, input logic [TAG-1:0] t, input logic [XLEN:0] obs);
        int              k;
        bit              rdy;
        logic [XLEN-1:0] d;
        k   = find(t);
        rdy = (k >= 0) && mq[k].done;
        d   = rdy ? mq[k].data : '0;
`ifdef ROB_CDB_BYPASS_EN
        if (cdb_valid && (k >= 0) && (cdb_tag == t)) begin
            rdy = 1'b1;
            d   = cdb_data;
        end
`endif
        if (rdy) check(nm, 64'(obs), 64'({1'b1, d}));
        else     check({nm, ".ready"}, 64'(obs[XLEN]), 64'(0));
    endtask

    task automatic model_clear(input bit clr_port);
        mq.delete();
        m_tail = 0;
        m_we   = 1'b0;
        if (clr_port) begin
            m_wa = '0;
            m_wd = '0;
        end
    endtask

    // Apply one clock edge's worth of rules to the model
    task automatic step_model();
        bit   com;
        bit   al;
        int   k;
        ent_t e;
        if (flush) begin
            model_clear(1'b0);
        end else begin
            com = (mq.size() > 0) && mq[0].done;
            al  = alloc_valid && (mq.size() < DEPTH);
            k   = cdb_valid ? find(cdb_tag) : -1;
            if (com) begin
                m_we = (mq[0].rd != '0);
                m_wa = mq[0].rd;
                m_wd = mq[0].data;
            end else begin
                m_we = 1'b0;
            end
            if (k >= 0) begin
                e      = mq[k];
                e.done = 1'b1;
                e.data = cdb_data;
                mq[k]  = e;
            end
            if (com) void'(mq.pop_front());
            if (al) begin
                e.tag  = TAG'(m_tail);
                e.rd   = alloc_rd;
                e.done = 1'b0;
                e.data = '0;
                mq.push_back(e);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
    endtask

    task automatic chk_comb();
        check("alloc_ready", 64'(alloc_ready), 64'(mq.size() < DEPTH));
        check("tailD", 64'(tailD), 64'(m_tail));
        check("count", 64'(count), 64'(mq.size()));
        check("empty", 64'(empty), 64'(mq.size() == 0));
        chk_rv("RV1", RT1, RV1);
        chk_rv("RV2", RT2, RV2);
    endtask

    task automatic chk_regs();
        check("WE_W", 64'(WE_W), 64'(m_we));
        check("WA_W", 64'(WA_W), 64'(m_wa));
        check("WD", 64'(WD), 64'(m_wd));
    endtask

    // Inputs are already driven; check, advance one edge, check registers
    task automatic cyc();
        #1;
        chk_comb();
        step_model();
        @(posedge clk);
        #1;
        chk_regs();
    endtask

    task automatic idle();
        flush       = 1'b0;
        alloc_valid = 1'b0;
        alloc_rd    = '0;
        cdb_valid   = 1'b0;
        cdb_tag     = '0;
        cdb_data    = '0;
        RT1         = '0;
        RT2         = '0;
    endtask

    task automatic wb(input int t, input logic [XLEN-1:0] d);
        cdb_valid = 1'b1;
        cdb_tag   = TAG'(t);
        cdb_data  = d;
    endtask

    // Asynchronous reset mid-stream: outputs must clear before any edge
    task automatic async_reset();
        rstn = 1'b0;
        #1;
        model_clear(1'b1);
        chk_comb();
        chk_regs();
        @(posedge clk);
        #1;
        chk_regs();
        rstn = 1'b1;
    endtask

    function automatic logic [TAG-1:0] pick_tag();
        if ((mq.size() > 0) && ($urandom_range(0, 3) != 0))
            return mq[$urandom_range(0, mq.size() - 1)].tag;
        return TAG'($urandom);
    endfunction

    initial begin
        n_pass  = 0;
        n_total = 0;
        idle();
        rstn = 1'b0;
        model_clear(1'b1);
        #3;
        chk_comb();
        chk_regs();
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Three allocations get tags 0,1,2
        alloc_valid = 1'b1;
        alloc_rd = 5'd3; cyc();
        alloc_rd = 5'd5; cyc();
        alloc_rd = 5'd7; cyc();
        idle(); cyc();

        // Out-of-order writebacks retire in order
        wb(1, 32'h0000_AAAA); cyc();
        wb(0, 32'h0000_5555); cyc();
        idle(); cyc();
        cyc();
        cyc();

        // Finish tag 2 (rd=7), then an rd=0 entry retires silently
        wb(2, 32'h0000_0077); cyc();
        idle(); alloc_valid = 1'b1; alloc_rd = 5'd0; cyc();
        idle(); cyc();
        wb(3, 32'hDEAD_BEEF); cyc();
        idle(); cyc();
        cyc();

        // Fill to capacity, 129th request ignored, then free one and wrap
        flush = 1'b1; cyc();
        idle();
        alloc_valid = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            alloc_rd = ADDR'($urandom);
            cyc();
        end
        wb(0, 32'h0BAD_F00D); cyc();
        cdb_valid = 1'b0; cyc();
        cyc();
        cyc();

        // Flush collides with alloc, writeback and commit
        idle(); wb(1, 32'h1111_1111); cyc();
        idle();
        flush = 1'b1; alloc_valid = 1'b1; alloc_rd = 5'd9;
        wb(2, 32'h2222_2222); RT1 = 7'd1;
        cyc();
        idle(); RT1 = 7'd1; RT2 = 7'd2; cyc();

        // Lookup of a tag being broadcast in the same cycle
        idle(); alloc_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            alloc_rd = ADDR'(i + 1);
            cyc();
        end
        idle(); wb(4, 32'h0000_1234); RT1 = 7'd4; RT2 = 7'd3; cyc();
        idle(); RT1 = 7'd4; cyc();
        cyc();

        // Random traffic with one asynchronous reset in the middle
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) async_reset();
            flush       = ($urandom_range(0, 99) < 1);
            alloc_valid = ($urandom_range(0, 99) < 60);
            alloc_rd    = ADDR'($urandom);
            cdb_valid   = ($urandom_range(0, 99) < 55);
            cdb_tag     = pick_tag();
            cdb_data    = $urandom;
            RT1         = pick_tag();
            RT2         = ($urandom_range(0, 1) == 1) ? cdb_tag : pick_tag();
            cyc();
        end
        idle();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rob_commit_unit.md
# rob_commit_unit

Reorder buffer feeding the renaming register file. Allocates one in-order entry per decoded instruction and returns its 7-bit tag on `tailD`. Captures execution results from the common data bus and retires completed entries in program order, driving the register file write-back port (`WE_W`, `WA_W`, `WD`). Also answers operand-tag lookups for the issue stage.

## Interface
- `TAG`, 7: tag width; depth = 2**TAG entries (128).
- `ADDR`, 5: architectural register address width.
- `XLEN`, 32: data width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous squash of all entries.
- `alloc_valid`  in  1  decode requests an entry.
- `alloc_rd`  in  ADDR  destination register of the allocating instruction.
- `alloc_ready`  out  1  entry available (not full).
- `tailD`  out  TAG  tag handed to the allocating instruction (current tail pointer).
- `cdb_valid`  in  1  result broadcast valid.
- `cdb_tag`  in  TAG  tag of the broadcast result.
- `cdb_data`  in  XLEN  broadcast result.
- `RT1`, `RT2`  in  TAG  operand tags to look up.
- `RV1`, `RV2`  out  1+XLEN  {ready, data} of the looked-up entry, combinational.
- `WE_W`  out  1  register file write enable (registered).
- `WA_W`  out  ADDR  register file write address (registered).
- `WD`  out  XLEN  register file write data (registered).
- `empty`  out  1  no valid entries.
- `count`  out  TAG+1  number of valid entries.

## Operation
- Each entry holds `valid`, `done`, `rd`, and `data`. `head` and `tail` are TAG-bit pointers that wrap modulo 2**TAG. `count` is tracked separately so full and empty are distinguishable.
- Allocate:
  - Fires when `alloc_valid && alloc_ready`.
  - Writes entry[tail] = {valid=1, done=0, rd=alloc_rd}, then tail <= tail+1.
  - `alloc_ready = (count != 2**TAG)`. A commit in the same cycle does not free a slot for that cycle's allocation.
  - Allocation while full is ignored, and tail is unchanged.
- Writeback:
  - When `cdb_valid` and entry[cdb_tag].valid, set done=1 and data=cdb_data.
  - Writeback to an invalid entry is ignored.
  - A repeat writeback overwrites the stored data.
- Commit:
  - Occurs when entry[head] has valid && done. That edge clears entry[head].valid and advances head <= head+1.
  - At the same edge it registers `WA_W`=rd and `WD`=data, with `WE_W` = (rd != 0).
  - With no commit, `WE_W` <= 0 and `WA_W`/`WD` hold their values.
  - At most one commit per cycle.
- Count update: `count` += alloc − commit. Simultaneous alloc and commit leaves `count` unchanged.
- Lookup: `RVn` = {entry[RTn].done, entry[RTn].data}. An invalid entry returns ready=0.
- Flush:
  - Has priority over alloc, writeback and commit in the same cycle.
  - Clears all valid/done bits, sets head=tail=0 and count=0, and forces `WE_W` <= 0.

## Timing
- Reset (async assert) sets: all entries invalid, head=tail=0, count=0, `alloc_ready`=1, `tailD`=0, `empty`=1, `WE_W`=0, `WA_W`=0, `WD`=0, `RVn` ready=0.
- Reset asserted mid-operation discards all in-flight state immediately. No commit is emitted afterwards.
- `tailD` is valid in the same cycle as `alloc_valid`. The next allocation receives tailD+1.
- Result latency:
  - Writeback at edge N sets done.
  - Commit decision is made at edge N+1.
  - `WE_W` is high during cycle N+1 to N+2.
  - A writeback landing on head therefore commits one cycle later, never in the same cycle.
- Wrap: tail 127 -> 0 and head 127 -> 0 with no bubble.
- Back-to-back commits: `WE_W` stays high on consecutive cycles while successive head entries are done.

## Configuration
- `ROB_CDB_BYPASS_EN` defined:
  - `RVn` returns {1, cdb_data} when `cdb_valid`, entry[RTn].valid and `cdb_tag`==RTn in the same cycle.
  - This is a combinational CDB-to-lookup path.
- `ROB_CDB_BYPASS_EN` undefined:
  - `RVn` reflects stored entry state only.
  - A broadcast becomes visible one cycle after `cdb_valid`.

## Test plan
- Reset, then allocate rd=3, 5, 7 on consecutive cycles -> `tailD`=0, 1, 2; `count`=3; `empty`=0; `WE_W`=0.
- Writeback tag 1 (0xAAAA) and then tag 0 (0x5555) -> commits occur in order: `WA_W`=3/`WD`=0x5555, then `WA_W`=5/`WD`=0xAAAA on the next cycle. Tag 2 stays pending.
- Allocate 128 entries -> `alloc_ready`=0 and a 129th request is ignored (`count`=128). After one commit, `alloc_ready` returns to 1 and the next tag wraps to 0.
- Entry with rd=0 completes -> head advances and `count` decrements, but `WE_W` stays 0.
- Flush asserted in the same cycle as alloc, writeback and commit -> `count`=0, `tailD`=0, `WE_W`=0 next cycle, and a lookup of the old tag returns ready=0.
- Lookup RT1=tag 4 while `cdb_tag`=4 is valid with 0x1234 -> RV1={1, 0x1234} same cycle with `ROB_CDB_BYPASS_EN` defined. Without it, RV1 ready=0 that cycle and {1, 0x1234} the next.
